// File: rtl/store_commit_queue.sv
// Store commit queue: accepts up to two retired stores per cycle, drains the
// oldest to data memory, and forwards the youngest matching store to loads.
module store_commit_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [64:0]              completed_inst_0,
  input  logic                     completed_inst_0_valid,
  input  logic [64:0]              completed_inst_1,
  input  logic                     completed_inst_1_valid,
  output logic                     sq_stall,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic                     mem_ready,
  input  logic [31:0]              load_addr,
  output logic                     fwd_hit,
  output logic [31:0]              fwd_data,
  output logic                     err_misaligned,
  output logic                     sq_empty,
  output logic [$clog2(DEPTH):0]   sq_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d, wr1_idx;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;

  logic [31:0] addr0, data0, addr1, data1;
  logic        ill0, ill1, live0, live1, enq0, enq1, deq;
  logic [1:0]  enq_n;
  logic        unused_ok;

  assign data0 = completed_inst_0[64:33];
  assign addr0 = completed_inst_0[32:1];
  assign ill0  = completed_inst_0[0];
  assign data1 = completed_inst_1[64:33];
  assign addr1 = completed_inst_1[32:1];
  assign ill1  = completed_inst_1[0];

  // Load byte offset is irrelevant: matching is at word granularity.
  assign unused_ok = ^load_addr[1:0];

  assign sq_count = count_q;
  assign sq_empty = (count_q == '0);
  assign sq_stall = (count_q > CW'(DEPTH - 2));

  assign live0 = completed_inst_0_valid & ~ill0;
  assign live1 = completed_inst_1_valid & ~ill1;
  assign enq0  = ~sq_stall & live0 & (addr0[1:0] == 2'b00);
  assign enq1  = ~sq_stall & live1 & (addr1[1:0] == 2'b00);
  assign enq_n = {1'b0, enq0} + {1'b0, enq1};
  // Slot 1 lands right behind slot 0 only if slot 0 was actually taken.
  assign wr1_idx = tail_q + AW'(enq0);

  assign deq = ~sq_empty & mem_ready;

  assign head_d  = head_q + AW'(deq);
  assign tail_d  = tail_q + AW'(enq_n);
  assign count_d = count_q + CW'(enq_n) - CW'(deq);
  assign err_d   = ~sq_stall &
                   ((live0 & (addr0[1:0] != 2'b00)) | (live1 & (addr1[1:0] != 2'b00)));

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Payload storage is never reset; occupancy alone decides visibility.
  always_ff @(posedge clk) begin
    if (enq0) begin
      addr_q[tail_q] <= addr0;
      data_q[tail_q] <= data0;
    end
    if (enq1) begin
      addr_q[wr1_idx] <= addr1;
      data_q[wr1_idx] <= data1;
    end
  end

  assign err_misaligned = err_q;
  assign mem_req        = ~sq_empty;
  assign mem_addr       = sq_empty ? '0 : addr_q[head_q];
  assign mem_wdata      = sq_empty ? '0 : data_q[head_q];

  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    logic [AW-1:0] idx;
    idx      = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + AW'(i);
      if ((CW'(i) < count_q) && (addr_q[idx][31:2] == load_addr[31:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

endmodule
